vga_pattern_scheduler: RTL and testbench

//   Frame-synchronous controller that chooses which test-pattern generator drives the VGA RGB mux.
//   - Sources: color strip, checker, solid, gradient.
//   - Switches come from manual requests (buttons or UART decoder) or from auto-cycling after a frame dwell.
//   - Switches are applied only at frame_start, so no frame ever tears.
//   - Sits between the input decoders and the pattern generators / RGB mux.

---
 rtl/vga_pattern_scheduler_pkg.sv | 22 ++
 rtl/vga_pattern_scheduler_if.sv | 12 +
 rtl/vga_pattern_scheduler_dwell.sv | 33 +++
 rtl/vga_pattern_scheduler.sv | 106 ++++++++++
 tb/tb_vga_pattern_scheduler.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pattern_scheduler_pkg.sv
// Shared types for the VGA pattern scheduler: pattern IDs, FSM state encoding
// and the wrap-around pattern stepping helper.
package vga_sched_pkg;

    typedef enum logic [2:0] {
        PAT_STRIP    = 3'd0,
        PAT_CHECKER  = 3'd1,
        PAT_SOLID    = 3'd2,
        PAT_GRADIENT = 3'd3
    } pat_id_e;

    typedef enum logic [1:0] {
        SHOW  = 2'd0,
        PEND  = 2'd1,
        BLANK = 2'd2
    } sched_state_e;

    function automatic logic [2:0] next_pat(input logic [2:0] cur, input int num);
        return (cur == 3'(num - 1)) ? 3'd0 : cur + 3'd1;
    endfunction

endpackage

// File: rtl/vga_pattern_scheduler_if.sv
// Manual pattern-request handshake between the input decoders and the scheduler.
interface vga_pattern_scheduler_if;
    import vga_sched_pkg::*;

    logic       req_valid;
    logic [2:0] req_mode;
    logic       req_ready;

    modport master (output req_valid, output req_mode, input  req_ready);
    modport slave  (input  req_valid, input  req_mode, output req_ready);

endinterface

// File: rtl/vga_pattern_scheduler_dwell.sv
// Frame dwell counter for auto-cycling: clears when auto is off or a manual
// switch is taken, holds on pause, counts frame_starts only while showing.
module sched_dwell_counter #(
    parameter int DWELL_FRAMES = 120,
    parameter int DW           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic auto_en,
    input  logic pause,
    input  logic run,
    input  logic clr,
    output logic expire
);
    logic [DW-1:0] dwell_cnt;
    logic          last;
    logic          tick;

    assign last   = (dwell_cnt == DW'(DWELL_FRAMES - 1));
    assign tick   = frame_start && auto_en && !pause;
    assign expire = last && tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dwell_cnt <= '0;
        else if (!auto_en || clr)
            dwell_cnt <= '0;
        else if (run && tick)
            dwell_cnt <= last ? '0 : dwell_cnt + 1'b1;
    end

endmodule

// File: rtl/vga_pattern_scheduler.sv
// Frame-synchronous pattern selector for the VGA RGB mux.
// Define PAT_SCHED_BLANK_EN to insert one black frame between patterns.
module vga_pattern_scheduler
    import vga_sched_pkg::*;
#(
    parameter int NUM_PATTERNS = 4,
    parameter int DWELL_FRAMES = 120,
    parameter int DW           = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    vga_pattern_scheduler_if.slave   req,
    input  logic                     auto_en,
    input  logic                     pause,
    output logic [2:0]               pat_sel,
    output logic                     pat_load,
    output logic                     force_black,
    output logic                     busy
);
    sched_state_e state;
    logic [2:0]   next_sel;
    logic         in_show;
    logic         manual_sw;
    logic         expire;

    assign in_show       = (state == SHOW);
    assign req.req_ready = in_show;
    assign busy          = !in_show;

    // Out-of-range or already-active IDs are accepted but never switch.
    assign manual_sw = in_show && req.req_valid
                    && ({1'b0, req.req_mode} < 4'(NUM_PATTERNS))
                    && (req.req_mode != pat_sel);

    sched_dwell_counter #(
        .DWELL_FRAMES (DWELL_FRAMES),
        .DW           (DW)
    ) u_dwell (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .auto_en     (auto_en),
        .pause       (pause),
        .run         (in_show),
        .clr         (manual_sw),
        .expire      (expire)
    );

`ifdef PAT_SCHED_BLANK_EN
    logic black_q;
    assign force_black = black_q;
`else
    assign force_black = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SHOW;
            pat_sel  <= 3'd0;
            pat_load <= 1'b0;
            next_sel <= 3'd0;
`ifdef PAT_SCHED_BLANK_EN
            black_q  <= 1'b0;
`endif
        end else begin
            pat_load <= 1'b0;
            case (state)
                SHOW: begin
                    // Manual request takes priority over a same-cycle auto expiry.
                    if (manual_sw) begin
                        next_sel <= req.req_mode;
                        state    <= PEND;
                    end else if (expire) begin
                        next_sel <= next_pat(pat_sel, NUM_PATTERNS);
                        state    <= PEND;
                    end
                end
                PEND: begin
                    if (frame_start) begin
`ifdef PAT_SCHED_BLANK_EN
                        black_q  <= 1'b1;
                        state    <= BLANK;
`else
                        pat_sel  <= next_sel;
                        pat_load <= 1'b1;
                        state    <= SHOW;
`endif
                    end
                end
                BLANK: begin
                    if (frame_start) begin
                        pat_sel  <= next_sel;
                        pat_load <= 1'b1;
`ifdef PAT_SCHED_BLANK_EN
                        black_q  <= 1'b0;
`endif
                        state    <= SHOW;
                    end
                end
                default: state <= SHOW;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Directed bench for vga_pattern_scheduler (short frames, DWELL_FRAMES=3);
// expectations follow PAT_SCHED_BLANK_EN when it is defined.
module tb_vga_pattern_scheduler;
    import vga_sched_pkg::*;

    localparam int FL = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       auto_en;
    logic       pause;
    logic [2:0] pat_sel;
    logic       pat_load;
    logic       force_black;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int loads  = 0;

    vga_pattern_scheduler_if req_if ();

    vga_pattern_scheduler #(
        .NUM_PATTERNS (4),
        .DWELL_FRAMES (3),
        .DW           (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .req         (req_if.slave),
        .auto_en     (auto_en),
        .pause       (pause),
        .pat_sel     (pat_sel),
        .pat_load    (pat_load),
        .force_black (force_black),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pat_load === 1'b1) loads++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Called at the end of the frame in which a switch was accepted.
    task automatic finish_switch(input string tag, input logic [2:0] exp);
`ifdef PAT_SCHED_BLANK_EN
        fs();
        chk({tag, "_black_on"}, force_black, 1);
        chk({tag, "_busy_blank"}, busy, 1);
        idle(FL - 1);
        chk({tag, "_black_hold"}, force_black, 1);
`endif
        fs();
        chk({tag, "_sel"}, pat_sel, exp);
        chk({tag, "_load"}, pat_load, 1);
        chk({tag, "_black_off"}, force_black, 0);
        chk({tag, "_busy_off"}, busy, 0);
        tick();
        chk({tag, "_load_1cyc"}, pat_load, 0);
    endtask

    initial begin
        rst_n            = 1'b0;
        frame_start      = 1'b0;
        auto_en          = 1'b0;
        pause            = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_mode  = 3'd0;
        idle(2);
        chk("rst_sel", pat_sel, 0);
        chk("rst_load", pat_load, 0);
        chk("rst_black", force_black, 0);
        chk("rst_ready", req_if.req_ready, 1);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Idle frames with auto disabled: nothing moves.
        for (int f = 0; f < 3; f++) begin
            fs();
            idle(FL - 1);
        end
        chk("idle_sel", pat_sel, 0);
        chk("idle_loads", loads, 0);
        chk("idle_black", force_black, 0);
        chk("idle_ready", req_if.req_ready, 1);

        // Mid-frame manual request for pattern 2.
        idle(3);
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 3'd2;
        tick();
        req_if.req_valid = 1'b0;
        chk("m2_busy", busy, 1);
        chk("m2_ready", req_if.req_ready, 0);
        chk("m2_sel_hold", pat_sel, 0);
        idle(4);
        finish_switch("m2", 3'd2);
        chk("m2_loads", loads, 1);

        // Request accepted on a frame_start edge: that frame_start is not used.
        idle(FL - 2);
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 3'd1;
        frame_start      = 1'b1;
        tick();
        req_if.req_valid = 1'b0;
        frame_start      = 1'b0;
        chk("fsacc_busy", busy, 1);
        chk("fsacc_sel_hold", pat_sel, 2);
        chk("fsacc_load", pat_load, 0);
        idle(FL - 1);
        finish_switch("fsacc", 3'd1);

        // Invalid and redundant requests are swallowed.
        idle(2);
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 3'd5;
        tick();
        chk("inv_busy", busy, 0);
        chk("inv_ready", req_if.req_ready, 1);
        req_if.req_mode  = 3'd1;
        tick();
        chk("red_busy", busy, 0);
        req_if.req_valid = 1'b0;
        chk("red_sel", pat_sel, 1);
        chk("red_loads", loads, 2);

        // Second request held against back-pressure, taken after the switch.
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 3'd2;
        tick();
        chk("bp_busy", busy, 1);
        req_if.req_mode  = 3'd3;
        idle(2);
        chk("bp_ready", req_if.req_ready, 0);
        idle(FL - 7);
        finish_switch("bp1", 3'd2);
        req_if.req_valid = 1'b0;
        chk("bp2_busy", busy, 1);
        idle(FL - 3);
        finish_switch("bp2", 3'd3);
        chk("bp_loads", loads, 4);

        // Auto-cycling wraps 3 -> 0 after three frames.
        auto_en = 1'b1;
        idle(FL - 2);
        fs();
        idle(FL - 1);
        fs();
        chk("auto_f2_busy", busy, 0);
        idle(FL - 1);
        fs();
        chk("auto_f3_busy", busy, 1);
        chk("auto_f3_sel", pat_sel, 3);
        idle(FL - 1);
        finish_switch("wrap", 3'd0);

        // Pause for five frames delays the next switch by five frames.
        idle(FL - 2);
        fs();
        idle(FL - 1);
        pause = 1'b1;
        for (int f = 0; f < 5; f++) begin
            fs();
            idle(FL - 1);
        end
        chk("pause_busy", busy, 0);
        pause = 1'b0;
        fs();
        idle(FL - 1);
        chk("pause_f7_busy", busy, 0);
        fs();
        chk("pause_f8_busy", busy, 1);
        idle(FL - 1);
        finish_switch("pause", 3'd1);
        auto_en = 1'b0;
        chk("auto_loads", loads, 6);

        // Reset while a switch is in flight drops it.
        idle(2);
        req_if.req_valid = 1'b1;
        req_if.req_mode  = 3'd2;
        tick();
        req_if.req_valid = 1'b0;
        idle(FL - 4);
`ifdef PAT_SCHED_BLANK_EN
        fs();
        chk("rstmid_black_pre", force_black, 1);
        idle(2);
`endif
        rst_n = 1'b0;
        #1;
        chk("rstmid_black", force_black, 0);
        chk("rstmid_sel", pat_sel, 0);
        chk("rstmid_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        fs();
        idle(FL - 1);
        fs();
        idle(2);
        chk("rstmid_sel_after", pat_sel, 0);
        chk("rstmid_loads", loads, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
